verin_ctrl: RTL and testbench



---
 rtl/verin_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_verin_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/verin_ctrl.sv
// Rudder actuator controller: serial ADC acquisition, PWM/direction drive and
// end-stop blocking, configured through a small Avalon-MM register bank.
module verin_ctrl #(
    parameter int ADC_BITS   = 12,
    parameter int LEAD_BITS  = 3,
    parameter int ADC_DIV    = 25,
    parameter int ACQ_PERIOD = 50000,
    parameter int PWM_BITS   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  address,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic        read,
    output logic [31:0] readdata,
    output logic        clk_adc,
    output logic        cs_n,
    input  logic        angle_barre,
    output logic        pwm,
    output logic        sens
);

    localparam int NBITS   = LEAD_BITS + ADC_BITS;
    localparam int ACQ_W   = $clog2(ACQ_PERIOD);
    localparam int DIV_W   = $clog2(ADC_DIV + 1);
    localparam int PULSE_W = $clog2(NBITS + 1);

    localparam logic [ACQ_W-1:0]   ACQ_LAST   = ACQ_W'(ACQ_PERIOD - 1);
    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(ADC_DIV - 1);
    localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(NBITS - 1);
    localparam logic [PULSE_W-1:0] PULSE_LEAD = PULSE_W'(LEAD_BITS);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} acq_state_t;

    acq_state_t          state, state_next;
    logic [PWM_BITS-1:0] period_reg, duty_reg, period_act, duty_act, pwm_cnt;
    logic [PWM_BITS-1:0] period_src, duty_src;
    logic [ADC_BITS-1:0] butee_g, butee_d, angle, shift_reg;
    logic [3:0]          cfg;
    logic                at_low, at_high, valid, blocked;
    logic [ACQ_W-1:0]    acq_cnt;
    logic [DIV_W-1:0]    div_cnt;
    logic [PULSE_W-1:0]  pulse_cnt;
    logic                acq_wrap, div_last, adc_fall, pulse_last;
    logic                pwm_stop, pwm_wrap, pwm_raw;
    logic                wr_period, wr_duty;
    logic                unused_bits;

    assign unused_bits = ^writedata;

    assign wr_period = write && (address == 3'd0);
    assign wr_duty   = write && (address == 3'd1);

    assign sens    = cfg[1];
    assign blocked = cfg[2] & valid & ((sens & at_high) | (~sens & at_low));

    always_ff @(posedge clk) begin
        if (reset) begin
            period_reg <= '0;
            duty_reg   <= '0;
            butee_g    <= '0;
            butee_d    <= '0;
            cfg        <= '0;
        end else if (write) begin
            case (address)
                3'd0:    period_reg <= writedata[PWM_BITS-1:0];
                3'd1:    duty_reg   <= writedata[PWM_BITS-1:0];
                3'd2:    butee_g    <= writedata[ADC_BITS-1:0];
                3'd3:    butee_d    <= writedata[ADC_BITS-1:0];
                3'd4:    cfg        <= writedata[3:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= '0;
        end else if (read) begin
            case (address)
                3'd0:    readdata <= 32'(period_reg);
                3'd1:    readdata <= 32'(duty_reg);
                3'd2:    readdata <= 32'(butee_g);
                3'd3:    readdata <= 32'(butee_d);
                3'd4:    readdata <= {28'd0, cfg};
                3'd5:    readdata <= 32'(angle);
                3'd6:    readdata <= {28'd0, blocked, valid, at_high, at_low};
                default: readdata <= '0;
            endcase
        end
    end

    // Acquisition rate counter; it keeps running through a frame so starts stay evenly spaced.
    assign acq_wrap = cfg[3] && (acq_cnt == ACQ_LAST);

    always_ff @(posedge clk) begin
        if (reset || !cfg[3] || acq_wrap) begin
            acq_cnt <= '0;
        end else begin
            acq_cnt <= acq_cnt + 1'b1;
        end
    end

    assign div_last   = (div_cnt == DIV_LAST);
    assign adc_fall   = (state == SHIFT) && div_last && clk_adc;
    assign pulse_last = (pulse_cnt == PULSE_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (acq_wrap) state_next = SETUP;
            SETUP:   if (div_last) state_next = SHIFT;
            SHIFT:   if (adc_fall && pulse_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Serial link: chip select follows the next state so it is low exactly during SETUP and SHIFT.
    always_ff @(posedge clk) begin
        if (reset) begin
            cs_n      <= 1'b1;
            clk_adc   <= 1'b0;
            div_cnt   <= '0;
            pulse_cnt <= '0;
            shift_reg <= '0;
            angle     <= '0;
            valid     <= 1'b0;
            at_low    <= 1'b0;
            at_high   <= 1'b0;
        end else begin
            cs_n <= !((state_next == SETUP) || (state_next == SHIFT));

            if ((state == SETUP) || (state == SHIFT)) begin
                div_cnt <= div_last ? '0 : div_cnt + 1'b1;
            end else begin
                div_cnt <= '0;
            end

            if (state == SHIFT) begin
                if (div_last) clk_adc <= ~clk_adc;
            end else begin
                clk_adc <= 1'b0;
            end

            if (state != SHIFT) begin
                pulse_cnt <= '0;
            end else if (adc_fall) begin
                pulse_cnt <= pulse_cnt + 1'b1;
                if (pulse_cnt >= PULSE_LEAD) begin
                    shift_reg <= {shift_reg[ADC_BITS-2:0], angle_barre};
                end
            end

            if (state == DONE) begin
                angle   <= shift_reg;
                valid   <= 1'b1;
                at_low  <= (shift_reg <= butee_g);
                at_high <= (shift_reg >= butee_d);
            end
        end
    end

    // Shadow registers pick up a same-cycle bus write so a write coinciding with a wrap is not lost.
    assign period_src = wr_period ? writedata[PWM_BITS-1:0] : period_reg;
    assign duty_src   = wr_duty   ? writedata[PWM_BITS-1:0] : duty_reg;
    assign pwm_stop   = !cfg[0] || (period_act == '0);
    assign pwm_wrap   = (pwm_cnt == period_act - 1'b1);

    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt    <= '0;
            period_act <= '0;
            duty_act   <= '0;
            pwm_raw    <= 1'b0;
        end else begin
            if (pwm_stop || pwm_wrap) begin
                pwm_cnt    <= '0;
                period_act <= period_src;
                duty_act   <= duty_src;
            end else begin
                pwm_cnt <= pwm_cnt + 1'b1;
            end
            pwm_raw <= cfg[0] && (period_act != '0) && (pwm_cnt < duty_act);
        end
    end

    assign pwm = pwm_raw & ~blocked;

endmodule

// File: tb/tb_verin_ctrl.sv
// Directed bench for verin_ctrl: register reads go through an expectation queue
// checked by a monitor; serial frames come from a behavioural ADC model.
module tb_verin_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  address = '0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic        read = 1'b0;
    logic [31:0] readdata;
    logic        clk_adc, cs_n, pwm, sens;
    logic        angle_barre = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];

    logic [11:0] adc_sample = 12'h000;
    logic [14:0] frame_bits;

    verin_ctrl #(
        .ADC_BITS(12), .LEAD_BITS(3), .ADC_DIV(2), .ACQ_PERIOD(200), .PWM_BITS(16)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .write(write),
        .writedata(writedata), .read(read), .readdata(readdata),
        .clk_adc(clk_adc), .cs_n(cs_n), .angle_barre(angle_barre),
        .pwm(pwm), .sens(sens)
    );

    always #5 clk = ~clk;

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] addr, input logic [31:0] data);
        @(negedge clk);
        address   = addr;
        writedata = data;
        write     = 1'b1;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [2:0] addr, input logic [31:0] exp);
        exp_q.push_back(exp);
        name_q.push_back(name);
        @(negedge clk);
        address = addr;
        read    = 1'b1;
        @(negedge clk);
        read = 1'b0;
    endtask

    task automatic waitCs(input logic level, input int limit, input string name);
        int n = 0;
        while (cs_n !== level && n < limit) begin
            @(negedge clk);
            n++;
        end
        compare(name, 32'(cs_n), 32'(level));
    endtask

    task automatic countHigh(input int n, output int highs);
        highs = 0;
        for (int i = 0; i < n; i++) begin
            if (pwm) highs++;
            @(negedge clk);
        end
    endtask

    task automatic waitRise(input string name);
        logic prev = pwm;
        int   n = 0;
        logic seen = 1'b0;
        while (!seen && n < 50) begin
            @(negedge clk);
            n++;
            if (pwm && !prev) seen = 1'b1;
            prev = pwm;
        end
        compare(name, 32'(seen), 32'd1);
    endtask

    // Read monitor: readdata must carry the expected word one cycle after read is sampled.
    initial begin
        forever begin
            @(posedge clk);
            if (read) begin
                #1;
                if (exp_q.size() == 0) begin
                    compare("unexpected_read", readdata, 32'hDEAD_BEEF);
                end else begin
                    compare(name_q.pop_front(), readdata, exp_q.pop_front());
                end
            end
        end
    end

    // ADC model: three null bits then the sample, MSB first, advanced after each clk_adc fall.
    initial begin
        forever begin
            @(negedge cs_n);
            #1;
            frame_bits  = {3'b000, adc_sample};
            angle_barre = frame_bits[14];
            for (int k = 0; k < 15; k++) begin
                @(negedge clk_adc or posedge cs_n);
                if (cs_n) break;
                #1;
                angle_barre = (k < 14) ? frame_bits[13 - k] : 1'b0;
            end
        end
    end

    initial begin
        int highs, cycles, pulses, rises, n;
        logic prev;

        $display("[TB] reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        compare("rst_outputs", {28'd0, cs_n, clk_adc, pwm, sens}, 32'h8);
        compare("rst_readdata", readdata, 32'h0);
        for (int a = 0; a < 8; a++) checkOutput($sformatf("rst_reg%0d", a), 3'(a), 32'h0);

        $display("[TB] adc frame");
        adc_sample = 12'hA5C;
        applyStimulus(3'd4, 32'h8);
        waitCs(1'b0, 400, "frame_start");
        cycles = 0;
        pulses = 0;
        prev   = 1'b0;
        while (cs_n == 1'b0 && cycles < 500) begin
            cycles++;
            if (clk_adc && !prev) pulses++;
            prev = clk_adc;
            @(negedge clk);
        end
        compare("frame_cs_low_cycles", 32'(cycles), 32'd62);
        compare("frame_pulses", 32'(pulses), 32'd15);
        checkOutput("angle_a5c", 3'd5, 32'hA5C);
        checkOutput("status_after_frame", 3'd6, 32'h6);

        $display("[TB] pwm");
        applyStimulus(3'd0, 32'd10);
        applyStimulus(3'd1, 32'd3);
        applyStimulus(3'd4, 32'h1);
        checkOutput("period_rb", 3'd0, 32'd10);
        checkOutput("duty_rb", 3'd1, 32'd3);
        repeat (5) @(negedge clk);
        countHigh(20, highs);
        compare("pwm_3_of_10", 32'(highs), 32'd6);
        waitRise("pwm_rise_a");
        applyStimulus(3'd1, 32'd7);
        @(negedge clk);
        compare("duty_not_early", 32'(pwm), 32'd0);
        waitRise("pwm_rise_b");
        countHigh(10, highs);
        compare("pwm_7_of_10", 32'(highs), 32'd7);
        applyStimulus(3'd1, 32'd12);
        repeat (25) @(negedge clk);
        countHigh(10, highs);
        compare("pwm_duty_over_period", 32'(highs), 32'd10);
        applyStimulus(3'd0, 32'd0);
        repeat (25) @(negedge clk);
        countHigh(10, highs);
        compare("pwm_period_zero", 32'(highs), 32'd0);

        $display("[TB] limits");
        adc_sample = 12'h900;
        applyStimulus(3'd3, 32'h800);
        applyStimulus(3'd0, 32'd10);
        applyStimulus(3'd1, 32'd12);
        applyStimulus(3'd4, 32'hF);
        waitCs(1'b0, 400, "limit_frame_start");
        waitCs(1'b1, 200, "limit_frame_end");
        repeat (2) @(negedge clk);
        checkOutput("angle_900", 3'd5, 32'h900);
        checkOutput("status_blocked", 3'd6, 32'hE);
        countHigh(10, highs);
        compare("pwm_blocked", 32'(highs), 32'd0);
        applyStimulus(3'd4, 32'hD);
        compare("unblock_same_cycle", {30'd0, sens, pwm}, 32'h1);
        checkOutput("status_unblocked", 3'd6, 32'h6);

        $display("[TB] reset mid-frame");
        waitCs(1'b0, 400, "midframe_start");
        rises = 0;
        prev  = clk_adc;
        n     = 0;
        while (rises < 6 && n < 300) begin
            @(negedge clk);
            n++;
            if (clk_adc && !prev) rises++;
            prev = clk_adc;
        end
        compare("midframe_rises", 32'(rises), 32'd6);
        reset = 1'b1;
        @(negedge clk);
        compare("midframe_reset_out", {28'd0, cs_n, clk_adc, pwm, sens}, 32'h8);
        reset = 1'b0;
        checkOutput("midframe_status", 3'd6, 32'h0);
        checkOutput("midframe_angle", 3'd5, 32'h0);
        adc_sample = 12'h3C7;
        applyStimulus(3'd4, 32'h8);
        n = 0;
        while (cs_n == 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        compare("acq_period_delay", 32'(n), 32'd200);
        waitCs(1'b1, 200, "refrm_end");
        repeat (2) @(negedge clk);
        checkOutput("angle_3c7", 3'd5, 32'h3C7);
        checkOutput("status_refrm", 3'd6, 32'h6);

        $display("[TB] readback");
        applyStimulus(3'd4, 32'hFFFF_FFFF);
        applyStimulus(3'd5, 32'hFFFF_FFFF);
        applyStimulus(3'd7, 32'hFFFF_FFFF);
        checkOutput("reserved_reg", 3'd7, 32'h0);
        checkOutput("config_masked", 3'd4, 32'hF);
        checkOutput("angle_ro", 3'd5, 32'h3C7);
        repeat (3) @(negedge clk);
        compare("readdata_hold", readdata, 32'h3C7);

        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        compare("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
